// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: register file, source/destination decode and a RUN/HALTED FSM.
// Optional macro DECODE_BYPASS_EN forwards same-cycle write data onto the read ports.
module decode_writeback #(
   parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200,
   parameter int          NREG     = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE,
   output logic [3:0]  dstM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   input  logic [3:0]  wb_dstE,
   input  logic [63:0] wb_valE,
   input  logic [3:0]  wb_dstM,
   input  logic [63:0] wb_valM,
   input  logic [2:0]  wb_stat,
   output logic        halted,
   input  logic [3:0]  dbg_addr,
   output logic [63:0] dbg_data
);

   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [3:0] RSP     = 4'h4;
   localparam logic [3:0] NREG_ID = 4'(NREG);
   localparam logic [2:0] STAT_AOK = 3'd1;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_t;

   state_t      state_q;
   logic        halted_q;
   logic [63:0] regs_q [NREG];
   logic [63:0] regs_d [NREG];
   logic        wr_en;

   assign wr_en = (state_q == ST_RUN) && !rst;

   // Array read with the register-none ID returning zero; optional same-cycle forwarding.
   function automatic logic [63:0] read_port(input logic [3:0] id);
      logic [63:0] v;
      v = '0;
      if (id < NREG_ID) v = regs_q[id];
`ifdef DECODE_BYPASS_EN
      if (wr_en && id != RNONE) begin
         if (wb_dstE == id) v = wb_valE;
         if (wb_dstM == id) v = wb_valM;
      end
`endif
      return v;
   endfunction

   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         4'd2:  begin srcA = rA;  dstE = rB; end
         4'd3:  begin dstE = rB; end
         4'd4:  begin srcA = rA;  srcB = rB; end
         4'd5:  begin srcB = rB;  dstM = rA; end
         4'd6:  begin srcA = rA;  srcB = rB;  dstE = rB; end
         4'd8:  begin srcB = RSP; dstE = RSP; end
         4'd9:  begin srcA = RSP; srcB = RSP; dstE = RSP; end
         4'd10: begin srcA = rA;  srcB = RSP; dstE = RSP; end
         4'd11: begin srcA = RSP; srcB = RSP; dstE = RSP; dstM = rA; end
         default: ;
      endcase
   end

   always_comb begin
      valA     = read_port(srcA);
      valB     = read_port(srcB);
      dbg_data = read_port(dbg_addr);
   end

   // M port is applied last so it wins when both ports target the same register.
   always_comb begin
      for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
      if (wr_en) begin
         if (wb_dstE != RNONE && wb_dstE < NREG_ID) regs_d[wb_dstE] = wb_valE;
         if (wb_dstM != RNONE && wb_dstM < NREG_ID) regs_d[wb_dstM] = wb_valM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= (i == 4) ? RSP_INIT : 64'd0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (wb_stat != STAT_AOK) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= ST_HALTED;
               halted_q <= 1'b1;
            end
         endcase
      end
   end

   assign halted = halted_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: expected register/halt state queued at stimulus time,
// checked through the debug port after the clock edge.
module tb_decode_writeback;

   localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200;
   localparam logic [3:0]  RN       = 4'hF;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  icode, rA, rB;
   logic [3:0]  srcA, srcB, dstE, dstM;
   logic [63:0] valA, valB;
   logic [3:0]  wb_dstE, wb_dstM;
   logic [63:0] wb_valE, wb_valM;
   logic [2:0]  wb_stat;
   logic        halted;
   logic [3:0]  dbg_addr;
   logic [63:0] dbg_data;

   decode_writeback #(.RSP_INIT(RSP_INIT), .NREG(15)) dut (
      .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB),
      .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
      .valA(valA), .valB(valB),
      .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
      .wb_stat(wb_stat), .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      bit          is_halt;
      logic [3:0]  addr;
      logic [63:0] val;
   } exp_t;

   exp_t        sb_q[$];
   logic [63:0] m_regs [15];
   bit          m_run;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_state(input string name);
      exp_t e;
      for (int i = 0; i < 15; i++) begin
         e.tag = $sformatf("%s_R%0d", name, i);
         e.is_halt = 1'b0;
         e.addr = 4'(i);
         e.val = m_regs[i];
         sb_q.push_back(e);
      end
      e.tag = $sformatf("%s_RF", name);
      e.is_halt = 1'b0;
      e.addr = RN;
      e.val = '0;
      sb_q.push_back(e);
      e.tag = $sformatf("%s_halted", name);
      e.is_halt = 1'b1;
      e.addr = '0;
      e.val = m_run ? 64'd0 : 64'd1;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.is_halt) begin
            check_val(e.tag, {63'd0, halted}, e.val);
         end else begin
            dbg_addr = e.addr;
            #1;
            check_val(e.tag, dbg_data, e.val);
         end
      end
   endtask

   task automatic idle_wb();
      wb_dstE = RN; wb_valE = '0; wb_dstM = RN; wb_valM = '0; wb_stat = 3'd1;
   endtask

   task automatic apply_wb(input string name, input logic [3:0] de, input logic [63:0] ve,
                           input logic [3:0] dm, input logic [63:0] vm, input logic [2:0] st);
      @(negedge clk);
      wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm; wb_stat = st;
      if (m_run) begin
         if (de != RN) m_regs[de] = ve;
         if (dm != RN) m_regs[dm] = vm;
         if (st != 3'd1) m_run = 1'b0;
      end
      push_state(name);
      @(posedge clk);
      #1;
      idle_wb();
      drain();
   endtask

   task automatic do_reset(input string name, input logic [3:0] de, input logic [63:0] ve);
      @(negedge clk);
      rst = 1'b1;
      wb_dstE = de; wb_valE = ve;
      for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? RSP_INIT : 64'd0;
      m_run = 1'b1;
      push_state(name);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_wb();
      drain();
   endtask

   function automatic logic [15:0] ref_decode(input logic [3:0] ic, input logic [3:0] a,
                                              input logic [3:0] b);
      logic [3:0] sa, sb, de, dm;
      sa = (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) ? a : (ic inside {4'd9, 4'd11}) ? 4'd4 : RN;
      sb = (ic inside {4'd4, 4'd5, 4'd6}) ? b : (ic inside {[4'd8:4'd11]}) ? 4'd4 : RN;
      de = (ic inside {4'd2, 4'd3, 4'd6}) ? b : (ic inside {[4'd8:4'd11]}) ? 4'd4 : RN;
      dm = (ic inside {4'd5, 4'd11}) ? a : RN;
      return {sa, sb, de, dm};
   endfunction

   initial begin
      logic [15:0] r;
      rst = 1'b0; icode = '0; rA = RN; rB = RN; dbg_addr = '0; m_run = 1'b1;
      idle_wb();

      do_reset("reset", RN, '0);

      for (int i = 0; i < 16; i++) begin
         icode = 4'(i); rA = 4'd2; rB = 4'd3;
         #1;
         r = ref_decode(icode, rA, rB);
         check_val($sformatf("dec%0d_srcA", i), {60'd0, srcA}, {60'd0, r[15:12]});
         check_val($sformatf("dec%0d_srcB", i), {60'd0, srcB}, {60'd0, r[11:8]});
         check_val($sformatf("dec%0d_dstE", i), {60'd0, dstE}, {60'd0, r[7:4]});
         check_val($sformatf("dec%0d_dstM", i), {60'd0, dstM}, {60'd0, r[3:0]});
      end
      icode = 4'd11; rA = 4'd7; rB = RN;
      #1;
      check_val("popq_srcA", {60'd0, srcA}, 64'd4);
      check_val("popq_srcB", {60'd0, srcB}, 64'd4);
      check_val("popq_dstE", {60'd0, dstE}, 64'd4);
      check_val("popq_dstM", {60'd0, dstM}, 64'd7);

      apply_wb("dual", 4'd1, 64'hAA, 4'd2, 64'hBB, 3'd1);
      icode = 4'd6; rA = 4'd1; rB = 4'd2;
      #1;
      check_val("rd_valA", valA, 64'hAA);
      check_val("rd_valB", valB, 64'hBB);
      icode = 4'd12;
      #1;
      check_val("inv_valA", valA, 64'd0);
      check_val("inv_valB", valB, 64'd0);

      apply_wb("wr_none", RN, 64'h123, RN, 64'h456, 3'd1);
      apply_wb("conflict", 4'd4, 64'h1F8, 4'd4, 64'h55, 3'd1);
      apply_wb("pre_byp", 4'd3, 64'h5, 4'd14, 64'hE0E0, 3'd1);

      // Same-cycle read of a register being written.
      @(negedge clk);
      icode = 4'd2; rA = 4'd3; rB = 4'd0;
      wb_dstE = 4'd3; wb_valE = 64'h12;
      #1;
`ifdef DECODE_BYPASS_EN
      check_val("byp_valA", valA, 64'h12);
`else
      check_val("byp_valA", valA, 64'h5);
`endif
      m_regs[3] = 64'h12;
      @(posedge clk);
      #1;
      idle_wb();
      check_val("byp_next_valA", valA, 64'h12);
      @(negedge clk);
      wb_dstE = 4'd3; wb_valE = 64'h1; wb_dstM = 4'd3; wb_valM = 64'h2;
      #1;
`ifdef DECODE_BYPASS_EN
      check_val("byp_prio_valA", valA, 64'h2);
`else
      check_val("byp_prio_valA", valA, 64'h12);
`endif
      m_regs[3] = 64'h2;
      push_state("byp_prio");
      @(posedge clk);
      #1;
      idle_wb();
      drain();

      // Reset asserted alongside a write: no forwarding, and reset wins.
      @(negedge clk);
      icode = 4'd2; rA = 4'd1;
      wb_dstE = 4'd1; wb_valE = 64'h5;
      rst = 1'b1;
      #1;
      check_val("rst_byp_valA", valA, 64'hAA);
      rst = 1'b0;
      idle_wb();
      do_reset("rst_mid", 4'd1, 64'h5);

      apply_wb("halt", 4'd5, 64'h77, RN, '0, 3'd2);
      apply_wb("halted_wr", 4'd6, 64'h99, 4'd7, 64'h9A, 3'd1);
      @(negedge clk);
      icode = 4'd2; rA = 4'd6;
      wb_dstE = 4'd6; wb_valE = 64'h99;
      #1;
      check_val("halt_byp_valA", valA, 64'd0);
      idle_wb();
      do_reset("post_halt", RN, '0);

      apply_wb("stat0", 4'd8, 64'h88, RN, '0, 3'd0);
      do_reset("post_stat0", RN, '0);
      apply_wb("stat7", RN, '0, 4'd9, 64'h99, 3'd7);
      do_reset("post_stat7", RN, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
